// File: rtl/clock_pkg.sv
// Shared field widths, limits, FSM states and time pack/unpack helpers for clock_set_ctrl.
package clock_pkg;

  localparam int HR_W   = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int MS_W   = 10;
  localparam int TIME_W = HR_W + MIN_W + SEC_W + MS_W;

  localparam logic [HR_W-1:0]  HMAX_12 = 5'd11;
  localparam logic [HR_W-1:0]  HMAX_24 = 5'd23;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_HR   = 3'd1,
    SET_MIN  = 3'd2,
    COMMIT   = 3'd3
`ifdef CLOCK_SET_ALARM_EN
    ,
    SET_AHR  = 3'd4,
    SET_AMIN = 3'd5
`endif
  } state_t;

  typedef struct packed {
    logic [HR_W-1:0]  hr;
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
    logic [MS_W-1:0]  ms;
  } time_t;

  function automatic logic [TIME_W-1:0] pack_time(input logic [HR_W-1:0]  hr,
                                                  input logic [MIN_W-1:0] min,
                                                  input logic [SEC_W-1:0] sec,
                                                  input logic [MS_W-1:0]  ms);
    return {hr, min, sec, ms};
  endfunction

  function automatic time_t unpack_time(input logic [TIME_W-1:0] t);
    return time_t'(t);
  endfunction

endpackage

// File: rtl/wrap_updown.sv
// Modulo up/down stepper for one time field: wraps within 0..max, inc and dec together cancel.
module wrap_updown #(
  parameter int W = 6
) (
  input  logic [W-1:0] val,
  input  logic [W-1:0] max,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] nxt
);

  always_comb begin
    nxt = val;
    if (inc && !dec) begin
      nxt = (val >= max) ? '0 : val + 1'b1;
    end else if (dec && !inc) begin
      // an out-of-range value steps down onto the range top
      nxt = ((val == '0) || (val > max)) ? max : val - 1'b1;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting / DST front end issuing atomic loads to the time-of-day counter core.
// Define CLOCK_SET_ALARM_EN to add alarm editing states and the alarm match pulse.
module clock_set_ctrl #(
  parameter int TIME_W      = 27,
  parameter int TIMEOUT_CYC = 30000,
  parameter int BLINK_HALF  = 250
) (
  input  logic              kh_clk,
  input  logic              reset,
  input  logic              hour_mode_24,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic              dst_fwd_req,
  input  logic              dst_back_req,
  input  logic [TIME_W-1:0] cur_time,
  input  logic              load_ready,
  output logic              load_valid,
  output logic [TIME_W-1:0] load_time,
  output logic              run_en,
  output logic [1:0]        edit_field,
  output logic              blink
`ifdef CLOCK_SET_ALARM_EN
  ,
  output logic              alarm
`endif
);

  import clock_pkg::*;

  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int BL_W = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

  state_t             state_reg, state_next;
  logic [HR_W-1:0]    edit_hr_reg, edit_hr_next;
  logic [MIN_W-1:0]   edit_min_reg, edit_min_next;
  logic               load_valid_reg, load_valid_next;
  logic [TIME_W-1:0]  load_time_reg, load_time_next;
  logic               run_en_reg, run_en_next;
  logic [1:0]         edit_field_reg, edit_field_next;
  logic               blink_reg, blink_next;
  logic [BL_W-1:0]    blink_cnt_reg, blink_cnt_next;
  logic [TO_W-1:0]    timeout_cnt_reg, timeout_cnt_next;

  time_t              cur;
  logic [HR_W-1:0]    hmax;
  logic [HR_W-1:0]    hr_step, dst_hr;
  logic [MIN_W-1:0]   min_step;
  logic               btn_any, dst_up, dst_dn, in_set, next_in_set;

  assign cur     = unpack_time(cur_time);
  assign hmax    = hour_mode_24 ? HMAX_24 : HMAX_12;
  assign btn_any = btn_mode | btn_inc | btn_dec;
  assign dst_up  = dst_fwd_req & ~dst_back_req;
  assign dst_dn  = dst_back_req & ~dst_fwd_req;

  function automatic logic is_set(input state_t s);
    return (s != RUN) && (s != COMMIT);
  endfunction

  assign in_set      = is_set(state_reg);
  assign next_in_set = is_set(state_next);

  // Hour edit takes both button steps and DST shifts; opposing requests cancel.
  wrap_updown #(.W(HR_W)) u_hr_step (
    .val(edit_hr_reg), .max(hmax),
    .inc((btn_inc & ~btn_dec) | dst_up), .dec((btn_dec & ~btn_inc) | dst_dn),
    .nxt(hr_step)
  );

  wrap_updown #(.W(MIN_W)) u_min_step (
    .val(edit_min_reg), .max(MIN_MAX), .inc(btn_inc), .dec(btn_dec), .nxt(min_step)
  );

  wrap_updown #(.W(HR_W)) u_dst_step (
    .val(cur.hr), .max(hmax), .inc(dst_up), .dec(dst_dn), .nxt(dst_hr)
  );

`ifdef CLOCK_SET_ALARM_EN
  logic [HR_W-1:0]  alarm_hr_reg, alarm_hr_next, ahr_step;
  logic [MIN_W-1:0] alarm_min_reg, alarm_min_next, amin_step;
  logic             alarm_reg;

  wrap_updown #(.W(HR_W)) u_ahr_step (
    .val(alarm_hr_reg), .max(hmax), .inc(btn_inc), .dec(btn_dec), .nxt(ahr_step)
  );

  wrap_updown #(.W(MIN_W)) u_amin_step (
    .val(alarm_min_reg), .max(MIN_MAX), .inc(btn_inc), .dec(btn_dec), .nxt(amin_step)
  );
`endif

  always_comb begin
    state_next       = state_reg;
    edit_hr_next     = edit_hr_reg;
    edit_min_next    = edit_min_reg;
    load_time_next   = load_time_reg;
    timeout_cnt_next = '0;
`ifdef CLOCK_SET_ALARM_EN
    alarm_hr_next    = alarm_hr_reg;
    alarm_min_next   = alarm_min_reg;
`endif
    case (state_reg)
      RUN: begin
        if (btn_mode) begin
          edit_hr_next  = cur.hr;
          edit_min_next = cur.min;
          state_next    = SET_HR;
        end else if (dst_up || dst_dn) begin
          load_time_next = pack_time(dst_hr, cur.min, cur.sec, cur.ms);
          state_next     = COMMIT;
        end
      end
      SET_HR: begin
        edit_hr_next = hr_step;
        if (btn_mode) state_next = SET_MIN;
      end
      SET_MIN: begin
        edit_min_next = min_step;
        if (btn_mode) begin
`ifdef CLOCK_SET_ALARM_EN
          state_next = SET_AHR;
`else
          load_time_next = pack_time(edit_hr_reg, min_step, '0, '0);
          state_next     = COMMIT;
`endif
        end
      end
`ifdef CLOCK_SET_ALARM_EN
      SET_AHR: begin
        alarm_hr_next = ahr_step;
        if (btn_mode) state_next = SET_AMIN;
      end
      SET_AMIN: begin
        alarm_min_next = amin_step;
        if (btn_mode) begin
          load_time_next = pack_time(edit_hr_reg, edit_min_reg, '0, '0);
          state_next     = COMMIT;
        end
      end
`endif
      COMMIT: begin
        if (load_valid_reg && load_ready) state_next = RUN;
      end
      default: state_next = RUN;
    endcase

    if (in_set) begin
      if (btn_any) begin
        timeout_cnt_next = '0;
      end else if (timeout_cnt_reg == TO_LAST) begin
        state_next = RUN;
      end else begin
        timeout_cnt_next = timeout_cnt_reg + 1'b1;
      end
      // a 24h->12h switch can strand the edit hour above the new range
      if (edit_hr_reg > hmax) edit_hr_next = '0;
`ifdef CLOCK_SET_ALARM_EN
      if (alarm_hr_reg > hmax) alarm_hr_next = '0;
`endif
    end
  end

  always_comb begin
    load_valid_next = (state_next == COMMIT);
    run_en_next     = run_en_reg;
    edit_field_next = 2'd0;
    blink_next      = 1'b0;
    blink_cnt_next  = '0;
    case (state_next)
      RUN:     run_en_next = 1'b1;
      COMMIT:  run_en_next = run_en_reg;
      default: run_en_next = 1'b0;
    endcase
    case (state_next)
      SET_HR:   edit_field_next = 2'd1;
      SET_MIN:  edit_field_next = 2'd2;
`ifdef CLOCK_SET_ALARM_EN
      SET_AHR:  edit_field_next = 2'd1;
      SET_AMIN: edit_field_next = 2'd2;
`endif
      default:  edit_field_next = 2'd0;
    endcase
    // blink phase only runs while staying inside the edit states
    if (in_set && next_in_set) begin
      if (blink_cnt_reg == BL_LAST) begin
        blink_next = ~blink_reg;
      end else begin
        blink_next     = blink_reg;
        blink_cnt_next = blink_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge kh_clk or posedge reset) begin
    if (reset) begin
      state_reg       <= RUN;
      edit_hr_reg     <= '0;
      edit_min_reg    <= '0;
      load_valid_reg  <= 1'b0;
      load_time_reg   <= '0;
      run_en_reg      <= 1'b1;
      edit_field_reg  <= 2'd0;
      blink_reg       <= 1'b0;
      blink_cnt_reg   <= '0;
      timeout_cnt_reg <= '0;
    end else begin
      state_reg       <= state_next;
      edit_hr_reg     <= edit_hr_next;
      edit_min_reg    <= edit_min_next;
      load_valid_reg  <= load_valid_next;
      load_time_reg   <= load_time_next;
      run_en_reg      <= run_en_next;
      edit_field_reg  <= edit_field_next;
      blink_reg       <= blink_next;
      blink_cnt_reg   <= blink_cnt_next;
      timeout_cnt_reg <= timeout_cnt_next;
    end
  end

`ifdef CLOCK_SET_ALARM_EN
  always_ff @(posedge kh_clk or posedge reset) begin
    if (reset) begin
      alarm_hr_reg  <= '0;
      alarm_min_reg <= '0;
      alarm_reg     <= 1'b0;
    end else begin
      alarm_hr_reg  <= alarm_hr_next;
      alarm_min_reg <= alarm_min_next;
      alarm_reg     <= (state_reg == RUN) && (cur.hr == alarm_hr_reg) &&
                       (cur.min == alarm_min_reg) && (cur.sec == '0) && (cur.ms == '0);
    end
  end

  assign alarm = alarm_reg;
`endif

  assign load_valid = load_valid_reg;
  assign load_time  = load_time_reg;
  assign run_en     = run_en_reg;
  assign edit_field = edit_field_reg;
  assign blink      = blink_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Randomized self-checking bench for clock_set_ctrl against a modular-arithmetic time model.
module tb_clock_set_ctrl;

  localparam int TW = 27;
  localparam int TO = 200;
  localparam int BH = 5;

  logic          kh_clk = 1'b0;
  logic          reset;
  logic          hour_mode_24, btn_mode, btn_inc, btn_dec, dst_fwd_req, dst_back_req;
  logic [TW-1:0] cur_time;
  logic          load_ready;
  logic          load_valid;
  logic [TW-1:0] load_time;
  logic          run_en;
  logic [1:0]    edit_field;
  logic          blink;
`ifdef CLOCK_SET_ALARM_EN
  logic          alarm;
`endif

  int checks = 0;
  int passed = 0;

  always #5 kh_clk = ~kh_clk;

  clock_set_ctrl #(.TIME_W(TW), .TIMEOUT_CYC(TO), .BLINK_HALF(BH)) dut (
    .kh_clk(kh_clk), .reset(reset), .hour_mode_24(hour_mode_24),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .dst_fwd_req(dst_fwd_req), .dst_back_req(dst_back_req),
    .cur_time(cur_time), .load_ready(load_ready),
    .load_valid(load_valid), .load_time(load_time), .run_en(run_en),
    .edit_field(edit_field), .blink(blink)
`ifdef CLOCK_SET_ALARM_EN
    , .alarm(alarm)
`endif
  );

  function automatic logic [TW-1:0] mk(input int h, input int m, input int s, input int ms);
    logic [4:0] hh = 5'(h);
    logic [5:0] mm = 6'(m);
    logic [5:0] ss = 6'(s);
    logic [9:0] xx = 10'(ms);
    return {hh, mm, ss, xx};
  endfunction

  // reference: a field holding v in 0..maxv after a net of delta steps
  function automatic int wrap(input int v, input int delta, input int maxv);
    int n = maxv + 1;
    int r = (v + delta) % n;
    if (r < 0) r += n;
    return r;
  endfunction

  task automatic pulse(input bit m, input bit i, input bit d, input bit f, input bit b);
    btn_mode = m; btn_inc = i; btn_dec = d; dst_fwd_req = f; dst_back_req = b;
    @(negedge kh_clk);
    btn_mode = 0; btn_inc = 0; btn_dec = 0; dst_fwd_req = 0; dst_back_req = 0;
  endtask

  // alarm builds pass through two extra edit states before committing
  task automatic alarm_skip;
`ifdef CLOCK_SET_ALARM_EN
    pulse(1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
`endif
  endtask

  task automatic edit_steps(input int ninc, input int ndec);
    int a = ninc;
    int b = ndec;
    while (a + b > 0) begin
      if (b == 0 || (a > 0 && $urandom_range(0, 1) == 1)) begin
        pulse(0, 1, 0, 0, 0); a--;
      end else begin
        pulse(0, 0, 1, 0, 0); b--;
      end
    end
  endtask

  task automatic capture_load(output logic [TW-1:0] t, output int n, output logic ren);
    t = '0; n = 0; ren = 1'bx;
    for (int k = 0; k < 20; k++) begin
      if (load_valid === 1'b1) begin
        if (n == 0) begin t = load_time; ren = run_en; end
        n++;
      end else if (n > 0) begin
        break;
      end
      @(negedge kh_clk);
    end
    $display("load: %0d:%0d:%0d.%0d valid_cycles=%0d run_en=%b",
             t[26:22], t[21:16], t[15:10], t[9:0], n, ren);
  endtask

  task automatic run_session(input int h, input int m, input int m24, input int hi, input int hd,
                             input int mi, input int md, output logic [TW-1:0] t, output int n,
                             output logic ren);
    hour_mode_24 = m24[0];
    load_ready   = 1;
    cur_time     = mk(h, m, $urandom_range(0, 59), $urandom_range(0, 999));
    pulse(1, 0, 0, 0, 0);
    edit_steps(hi, hd);
    pulse(1, 0, 0, 0, 0);
    edit_steps(mi, md);
    pulse(1, 0, 0, 0, 0);
    alarm_skip();
    capture_load(t, n, ren);
  endtask

  task automatic test_reset;
    reset = 1; load_ready = 0; hour_mode_24 = 1; cur_time = mk(1, 2, 3, 4);
    btn_mode = 0; btn_inc = 0; btn_dec = 0; dst_fwd_req = 0; dst_back_req = 0;
    repeat (3) @(negedge kh_clk);
    checks++; if (load_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", load_valid); else passed++;
    checks++; if (load_time !== '0) $display("FAIL reset_time got %h exp 0", load_time); else passed++;
    checks++; if (run_en !== 1'b1) $display("FAIL reset_run_en got %b exp 1", run_en); else passed++;
    checks++; if (edit_field !== 2'd0) $display("FAIL reset_field got %0d exp 0", edit_field); else passed++;
    checks++; if (blink !== 1'b0) $display("FAIL reset_blink got %b exp 0", blink); else passed++;
    reset = 0;
    repeat (2) @(negedge kh_clk);
    checks++; if (run_en !== 1'b1 || load_valid !== 1'b0) $display("FAIL post_reset_idle got run_en=%b valid=%b exp 1/0", run_en, load_valid); else passed++;
  endtask

  task automatic test_basic;
    logic [TW-1:0] t; int n; logic ren;
    hour_mode_24 = 1; load_ready = 1; cur_time = mk(7, 42, 13, 500);
    pulse(1, 0, 0, 0, 0);
    checks++; if (edit_field !== 2'd1) $display("FAIL basic_field_hr got %0d exp 1", edit_field); else passed++;
    checks++; if (run_en !== 1'b0) $display("FAIL basic_run_en_edit got %b exp 0", run_en); else passed++;
    repeat (2) pulse(0, 1, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    checks++; if (edit_field !== 2'd2) $display("FAIL basic_field_min got %0d exp 2", edit_field); else passed++;
    repeat (43) pulse(0, 0, 1, 0, 0);
    pulse(1, 0, 0, 0, 0);
    alarm_skip();
    capture_load(t, n, ren);
    checks++; if (t !== mk(9, 59, 0, 0)) $display("FAIL basic_load_time got %h exp %h", t, mk(9, 59, 0, 0)); else passed++;
    checks++; if (n != 1) $display("FAIL basic_valid_cycles got %0d exp 1", n); else passed++;
    checks++; if (ren !== 1'b0) $display("FAIL basic_run_en_commit got %b exp 0", ren); else passed++;
    checks++; if (run_en !== 1'b1 || edit_field !== 2'd0) $display("FAIL basic_after got run_en=%b field=%0d exp 1/0", run_en, edit_field); else passed++;
  endtask

  task automatic test_wrap;
    logic [TW-1:0] t; int n; logic ren;
    run_session(11, 59, 0, 1, 0, 1, 0, t, n, ren);
    checks++; if (t !== mk(0, 0, 0, 0)) $display("FAIL wrap_12h_up got %h exp %h", t, mk(0, 0, 0, 0)); else passed++;
    run_session(0, 0, 1, 0, 1, 0, 0, t, n, ren);
    checks++; if (t !== mk(23, 0, 0, 0)) $display("FAIL wrap_24h_down got %h exp %h", t, mk(23, 0, 0, 0)); else passed++;
  endtask

  task automatic test_random_sessions;
    logic [TW-1:0] t, exp_t; int n; logic ren;
    for (int it = 0; it < 8; it++) begin
      int m24 = $urandom_range(0, 1);
      int hm  = m24 ? 23 : 11;
      int h   = $urandom_range(0, hm);
      int m   = $urandom_range(0, 59);
      int hi  = $urandom_range(0, 30);
      int hd  = $urandom_range(0, 30);
      int mi  = $urandom_range(0, 70);
      int md  = $urandom_range(0, 70);
      run_session(h, m, m24, hi, hd, mi, md, t, n, ren);
      exp_t = mk(wrap(h, hi - hd, hm), wrap(m, mi - md, 59), 0, 0);
      checks++; if (t !== exp_t || n != 1) $display("FAIL rand_session%0d got %h/%0d exp %h/1", it, t, n, exp_t); else passed++;
    end
  endtask

  task automatic test_dst;
    logic [TW-1:0] t, exp_t; int n; logic ren;
    hour_mode_24 = 0; load_ready = 0; cur_time = mk(11, 0, 5, 3);
    pulse(0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (load_valid !== 1'b1 || load_time !== mk(0, 0, 5, 3) || run_en !== 1'b1)
        $display("FAIL dst_hold%0d got valid=%b time=%h run_en=%b exp 1/%h/1", k, load_valid, load_time, run_en, mk(0, 0, 5, 3));
      else passed++;
      @(negedge kh_clk);
    end
    load_ready = 1;
    @(negedge kh_clk);
    checks++; if (load_valid !== 1'b0 || run_en !== 1'b1) $display("FAIL dst_done got valid=%b run_en=%b exp 0/1", load_valid, run_en); else passed++;
    for (int it = 0; it < 6; it++) begin
      int m24 = $urandom_range(0, 1);
      int hm  = m24 ? 23 : 11;
      int h   = $urandom_range(0, hm);
      int m   = $urandom_range(0, 59);
      int s   = $urandom_range(0, 59);
      int ms  = $urandom_range(0, 999);
      bit fwd = 1'($urandom_range(0, 1));
      hour_mode_24 = m24[0]; cur_time = mk(h, m, s, ms);
      pulse(0, 0, 0, fwd, ~fwd);
      capture_load(t, n, ren);
      exp_t = mk(wrap(h, fwd ? 1 : -1, hm), m, s, ms);
      checks++; if (t !== exp_t || n != 1 || ren !== 1'b1) $display("FAIL dst_rand%0d got %h/%0d/%b exp %h/1/1", it, t, n, ren, exp_t); else passed++;
    end
  endtask

  task automatic test_timeout;
    bit seen = 0;
    hour_mode_24 = 1; load_ready = 1; cur_time = mk(3, 3, 3, 3);
    pulse(1, 0, 0, 0, 0);
    checks++; if (edit_field !== 2'd1) $display("FAIL timeout_enter got %0d exp 1", edit_field); else passed++;
    repeat (TO - 1) begin if (load_valid) seen = 1; @(negedge kh_clk); end
    checks++; if (edit_field !== 2'd1) $display("FAIL timeout_early got %0d exp 1", edit_field); else passed++;
    @(negedge kh_clk);
    checks++; if (edit_field !== 2'd0 || run_en !== 1'b1) $display("FAIL timeout_expire got field=%0d run_en=%b exp 0/1", edit_field, run_en); else passed++;
    checks++; if (seen || load_valid !== 1'b0) $display("FAIL timeout_no_load got seen=%0d exp 0", seen); else passed++;
    pulse(1, 0, 0, 0, 0);
    repeat (TO - 2) @(negedge kh_clk);
    pulse(0, 1, 0, 0, 0);
    repeat (TO - 1) @(negedge kh_clk);
    checks++; if (edit_field !== 2'd1) $display("FAIL timeout_restart_hold got %0d exp 1", edit_field); else passed++;
    @(negedge kh_clk);
    checks++; if (edit_field !== 2'd0 || run_en !== 1'b1) $display("FAIL timeout_restart_expire got field=%0d run_en=%b exp 0/1", edit_field, run_en); else passed++;
  endtask

  task automatic test_simultaneous;
    logic [TW-1:0] t; int n; logic ren;
    hour_mode_24 = 1; load_ready = 1; cur_time = mk(5, 20, 1, 1);
    pulse(1, 0, 0, 0, 0);
    pulse(0, 1, 1, 0, 0);
    pulse(0, 0, 0, 1, 1);
    pulse(0, 0, 0, 1, 0);
    pulse(1, 1, 0, 0, 0);
    checks++; if (edit_field !== 2'd2) $display("FAIL simul_mode_inc_field got %0d exp 2", edit_field); else passed++;
    pulse(0, 1, 1, 0, 0);
    pulse(1, 0, 1, 0, 0);
    alarm_skip();
    capture_load(t, n, ren);
    checks++; if (t !== mk(7, 19, 0, 0)) $display("FAIL simul_load got %h exp %h", t, mk(7, 19, 0, 0)); else passed++;
    pulse(0, 0, 0, 1, 1);
    checks++; if (load_valid !== 1'b0) $display("FAIL simul_dst_run got %b exp 0", load_valid); else passed++;
  endtask

  task automatic test_mode_change;
    logic [TW-1:0] t; int n; logic ren;
    hour_mode_24 = 1; load_ready = 1; cur_time = mk(20, 15, 0, 9);
    pulse(1, 0, 0, 0, 0);
    hour_mode_24 = 0;
    @(negedge kh_clk);
    pulse(1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    alarm_skip();
    capture_load(t, n, ren);
    checks++; if (t !== mk(0, 15, 0, 0)) $display("FAIL mode_change_clamp got %h exp %h", t, mk(0, 15, 0, 0)); else passed++;
  endtask

  task automatic test_blink;
    logic [TW-1:0] t; int n; logic ren;
    hour_mode_24 = 1; load_ready = 1; cur_time = mk(2, 2, 2, 2);
    pulse(1, 0, 0, 0, 0);
    for (int k = 0; k < 3 * BH; k++) begin
      checks++; if (blink !== 1'((k / BH) % 2)) $display("FAIL blink_cyc%0d got %b exp %0d", k, blink, (k / BH) % 2); else passed++;
      @(negedge kh_clk);
    end
    pulse(1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    alarm_skip();
    capture_load(t, n, ren);
    checks++; if (blink !== 1'b0) $display("FAIL blink_run got %b exp 0", blink); else passed++;
  endtask

  task automatic test_reset_in_commit;
    load_ready = 0; hour_mode_24 = 1; cur_time = mk(4, 4, 4, 4);
    pulse(0, 0, 0, 1, 0);
    checks++; if (load_valid !== 1'b1) $display("FAIL rst_commit_pre got %b exp 1", load_valid); else passed++;
    #2 reset = 1;
    #1;
    checks++; if (load_valid !== 1'b0 || load_time !== '0) $display("FAIL rst_commit_async got valid=%b time=%h exp 0/0", load_valid, load_time); else passed++;
    checks++; if (run_en !== 1'b1 || edit_field !== 2'd0) $display("FAIL rst_commit_outs got run_en=%b field=%0d exp 1/0", run_en, edit_field); else passed++;
    @(negedge kh_clk);
    reset = 0; load_ready = 1;
    repeat (2) @(negedge kh_clk);
    checks++; if (load_valid !== 1'b0) $display("FAIL rst_commit_no_load got %b exp 0", load_valid); else passed++;
  endtask

`ifdef CLOCK_SET_ALARM_EN
  task automatic test_alarm;
    logic [TW-1:0] t; int n; logic ren; int cnt;
    logic [TW-1:0] seq [4];
    hour_mode_24 = 1; load_ready = 1; cur_time = mk(1, 2, 3, 4);
    pulse(1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    repeat (6) pulse(0, 1, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    repeat (30) pulse(0, 1, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    capture_load(t, n, ren);
    checks++; if (t !== mk(1, 2, 0, 0)) $display("FAIL alarm_session_load got %h exp %h", t, mk(1, 2, 0, 0)); else passed++;
    seq[0] = mk(6, 29, 59, 999); seq[1] = mk(6, 30, 0, 0); seq[2] = mk(6, 30, 0, 1); seq[3] = mk(6, 30, 0, 2);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      cur_time = seq[k];
      @(negedge kh_clk);
      if (alarm) cnt++;
    end
    checks++; if (cnt != 1) $display("FAIL alarm_pulse got %0d cycles exp 1", cnt); else passed++;
    cnt = 0;
    cur_time = mk(6, 30, 0, 1);
    repeat (4) begin @(negedge kh_clk); if (alarm) cnt++; end
    checks++; if (cnt != 0) $display("FAIL alarm_nonzero_ms got %0d cycles exp 0", cnt); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_random_sessions();
    test_dst();
    test_timeout();
    test_simultaneous();
    test_mode_change();
    test_blink();
    test_reset_in_commit();
`ifdef CLOCK_SET_ALARM_EN
    test_alarm();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
